// File: rtl/led_seq_monitor_pkg.sv
// led_seq_monitor_pkg: shared state encoding, error counter sizing and walking-one helpers
package led_seq_monitor_pkg;
  typedef enum logic {HUNT, TRACK} state_t;
  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam int MAXW = 32;
  function automatic logic is_onehot(input logic [MAXW-1:0] x);
    return x != '0 && (x & (x - MAXW'(1))) == '0;
  endfunction
  // The top bit re-enters at bit0; bits above w are masked off.
  function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] x, input int w);
    logic [MAXW-1:0] m;
    m = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    return ((x << 1) | (x >> (w - 1))) & m;
  endfunction
endpackage

// File: rtl/led_seq_monitor_if.sv
// led_seq_monitor_if: LED bus plus monitor status, driver side is master
interface led_seq_monitor_if
  import led_seq_monitor_pkg::*;
#(parameter int WIDTH = 8);
  localparam int SW = $clog2(WIDTH);
  logic en;
  logic [WIDTH-1:0] led;
  logic locked;
  logic [SW-1:0] step;
  logic wrap_pulse;
  logic err_pulse;
  logic [ERR_W-1:0] err_cnt;
  modport master(output en, led, input locked, step, wrap_pulse, err_pulse, err_cnt);
  modport slave(input en, led, output locked, step, wrap_pulse, err_pulse, err_cnt);
endinterface

// File: rtl/led_seq_monitor_onehot_idx.sv
// onehot_idx: index of the set bit in a one-hot vector, with a valid flag
module onehot_idx
  import led_seq_monitor_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [SW-1:0]    idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) idx = vec[i] ? (idx | SW'(i)) : idx;
    valid = is_onehot(MAXW'(vec));
  end
endmodule

// File: rtl/led_seq_monitor.sv
// led_seq_monitor: locks onto a rotating walking-one LED pattern and flags faults
module led_seq_monitor
  import led_seq_monitor_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HOLD       = 1,
  parameter int LOCK_STEPS = 4
) (
  input logic clk,
  input logic rst,
  led_seq_monitor_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int HW = $clog2(HOLD + 1);
  localparam int GW = $clog2(LOCK_STEPS + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] cur, cur_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [GW-1:0] good_cnt, good_n;
  logic locked, locked_n, wrap_pulse, wrap_n, err_pulse, err_n;
  logic [SW-1:0] step, step_n, idx;
  logic [ERR_W-1:0] err_cnt, cnt_n;
  logic valid, same, nxt, held;
  onehot_idx #(.WIDTH(WIDTH)) u_idx (.vec(bus.led), .idx(idx), .valid(valid));
  assign same = bus.led == cur;
  assign nxt  = bus.led == WIDTH'(rotl1(MAXW'(cur), WIDTH));
  assign held = hold_cnt == HW'(HOLD);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      cur        <= '0;
      hold_cnt   <= '0;
      good_cnt   <= '0;
      locked     <= 1'b0;
      step       <= '0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      hold_cnt   <= hold_n;
      good_cnt   <= good_n;
      locked     <= locked_n;
      step       <= step_n;
      wrap_pulse <= wrap_n;
      err_pulse  <= err_n;
      err_cnt    <= cnt_n;
    end
  end
  always_comb begin
    state_n  = state;
    cur_n    = cur;
    hold_n   = hold_cnt;
    good_n   = good_cnt;
    locked_n = locked;
    step_n   = step;
    wrap_n   = 1'b0;
    err_n    = 1'b0;
    cnt_n    = err_cnt;
    if (bus.en) begin
      if (state == HUNT) begin
        if (valid) begin
          state_n = TRACK;
          cur_n   = bus.led;
          step_n  = idx;
          hold_n  = HW'(1);
          good_n  = '0;
        end
      end else if (same && !held) begin
        hold_n = hold_cnt + HW'(1);
      end else if (nxt && held) begin
        cur_n    = bus.led;
        step_n   = idx;
        hold_n   = HW'(1);
        good_n   = (good_cnt == GW'(LOCK_STEPS)) ? good_cnt : good_cnt + GW'(1);
        locked_n = locked | (good_n == GW'(LOCK_STEPS));
        wrap_n   = cur[WIDTH-1] & locked;
      end else begin
        // Stall, early change, skip, reverse, multi-hot and zero all land here.
        err_n    = 1'b1;
        cnt_n    = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;
        locked_n = 1'b0;
        step_n   = '0;
        state_n  = HUNT;
      end
    end
  end
  assign bus.locked     = locked;
  assign bus.step       = step;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.err_pulse  = err_pulse;
  assign bus.err_cnt    = err_cnt;
endmodule

// File: tb/tb_led_seq_monitor.sv
// tb_led_seq_monitor: scoreboard bench, behavioural model predicts each cycle's outputs
module tb_led_seq_monitor;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  led_seq_monitor_if #(.WIDTH(8)) bus ();
  led_seq_monitor_if #(.WIDTH(8)) bus2 ();
  led_seq_monitor #(.WIDTH(8), .HOLD(1), .LOCK_STEPS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  led_seq_monitor #(.WIDTH(8), .HOLD(2), .LOCK_STEPS(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  typedef struct {
    bit locked;
    int step;
    bit wrap;
    bit err;
    int cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int wraps = 0;
  int errs2 = 0;
  bit m_trk, m_locked;
  logic [7:0] m_cur;
  int m_hold, m_good, m_step, m_err;
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask
  function automatic int bit_index(input logic [7:0] l);
    int r = 0;
    for (int i = 0; i < 8; i++) if (l[i]) r = i;
    return r;
  endfunction
  task automatic model(input bit r, input bit e, input logic [7:0] l);
    exp_t x;
    bit w = 0, f = 0;
    if (r) begin
      m_trk = 0; m_locked = 0; m_cur = 0; m_hold = 0; m_good = 0; m_step = 0; m_err = 0;
    end else if (e) begin
      if (!m_trk) begin
        if ($onehot(l)) begin
          m_trk = 1; m_cur = l; m_step = bit_index(l); m_hold = 1; m_good = 0;
        end
      end else if (l == m_cur && m_hold < 1) begin
        m_hold++;
      end else if (l == {m_cur[6:0], m_cur[7]} && m_hold == 1) begin
        w = m_cur[7] && m_locked;
        m_cur = l; m_step = bit_index(l); m_hold = 1;
        if (m_good < 4) m_good++;
        if (m_good == 4) m_locked = 1;
      end else begin
        f = 1;
        if (m_err < 255) m_err++;
        m_locked = 0; m_step = 0; m_trk = 0;
      end
    end
    x.locked = m_locked; x.step = m_step; x.wrap = w; x.err = f; x.cnt = m_err;
    q.push_back(x);
  endtask
  task automatic cycle(input bit r, input bit e, input logic [7:0] l);
    exp_t x;
    rst = r; bus.en = e; bus.led = l;
    model(r, e, l);
    @(posedge clk);
    #1;
    x = q.pop_front();
    if (bus.wrap_pulse) wraps++;
    check("locked", int'(bus.locked), int'(x.locked));
    check("step", int'(bus.step), x.step);
    check("wrap_pulse", int'(bus.wrap_pulse), int'(x.wrap));
    check("err_pulse", int'(bus.err_pulse), int'(x.err));
    check("err_cnt", int'(bus.err_cnt), x.cnt);
  endtask
  task automatic cycle2(input logic [7:0] l);
    bus2.en = 1; bus2.led = l;
    @(posedge clk);
    #1;
    if (bus2.err_pulse) errs2++;
  endtask
  initial begin
    logic [7:0] seq [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    bus.en = 0; bus.led = 0; bus2.en = 0; bus2.led = 0;
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'h00);
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00);
    wraps = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, seq[i]);
      if (i == 3) check("unlocked_before_0x10", int'(bus.locked), 0);
      if (i == 4) check("locked_after_0x10", int'(bus.locked), 1);
    end
    check("wrap_count", wraps, 1);
    cycle(0, 1, 8'h02);
    cycle(0, 1, 8'h03);
    check("fault_err_cnt", int'(bus.err_cnt), 1);
    for (int i = 2; i < 7; i++) cycle(0, 1, 8'h01 << i);
    check("relock", int'(bus.locked), 1);
    cycle(0, 1, 8'h80);
    cycle(0, 1, 8'h80);
    check("stall_err_cnt", int'(bus.err_cnt), 2);
    bus.en = 0;
    foreach (seq[i]) if (i < 5) begin cycle2(seq[i]); cycle2(seq[i]); end
    check("hold2_locked", int'(bus2.locked), 1);
    check("hold2_no_err", int'(bus2.err_cnt), 0);
    cycle2(8'h20);
    cycle2(8'h40);
    check("hold2_early_pulse", errs2, 1);
    check("hold2_early_cnt", int'(bus2.err_cnt), 1);
    check("hold2_early_unlock", int'(bus2.locked), 0);
    bus2.en = 0;
    for (int i = 0; i < 610; i++) cycle(0, 1, (i % 2) ? 8'h03 : 8'h01);
    check("err_saturate", int'(bus.err_cnt), 255);
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h01 << i);
    check("lock_before_freeze", int'(bus.locked), 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'hFF);
    check("frozen_locked", int'(bus.locked), 1);
    check("frozen_step", int'(bus.step), 4);
    cycle(1, 1, 8'h20);
    check("final_reset_cnt", int'(bus.err_cnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
